// File: rtl/k11_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operations, immediate formats
// and the decoded-instruction record passed from decoder to pipeline register.
package k11_pkg;

   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_SLL   = 4'd2,
      ALU_SLT   = 4'd3,
      ALU_SLTU  = 4'd4,
      ALU_XOR   = 4'd5,
      ALU_SRL   = 4'd6,
      ALU_SRA   = 4'd7,
      ALU_OR    = 4'd8,
      ALU_AND   = 4'd9,
      ALU_PASSB = 4'd10
   } alu_op_t;

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5
   } imm_fmt_t;

   typedef struct packed {
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      alu_op_t     alu_op;
      logic        use_rs1;
      logic        use_rs2;
      logic        we_rd;
      logic        is_load;
      logic        is_store;
      logic        is_branch;
      logic        is_jal;
      logic        is_jalr;
      logic [2:0]  funct3;
      logic        illegal;
   } dec_t;

   // All formats sign-extend from instr[31]; U-type already fills the top bits.
   function automatic logic [31:0] gen_imm(input imm_fmt_t fmt, input logic [31:0] instr);
      logic [31:0] imm;
      case (fmt)
         IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
         IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U:   imm = {instr[31:12], 12'b0};
         IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm = 32'b0;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/rv32i_decoder.sv
// Purely combinational RV32I decoder: raw instruction word to register
// indices, immediate, ALU operation and control flags.
module rv32i_decoder
   import k11_pkg::*;
(
   input  logic [31:0] instr,
   output dec_t        dec
);

   logic [6:0] opcode;
   logic [2:0] f3;
   logic [6:0] f7;
   imm_fmt_t   fmt;
   alu_op_t    alu_op;
   logic       ill;
   logic       use_rd;
   logic       use_rs1;
   logic       use_rs2;
   logic       is_load;
   logic       is_store;
   logic       is_branch;
   logic       is_jal;
   logic       is_jalr;

   assign opcode = instr[6:0];
   assign f3     = instr[14:12];
   assign f7     = instr[31:25];

   always_comb begin
      fmt       = IMM_NONE;
      alu_op    = ALU_ADD;
      ill       = 1'b0;
      use_rd    = 1'b0;
      use_rs1   = 1'b0;
      use_rs2   = 1'b0;
      is_load   = 1'b0;
      is_store  = 1'b0;
      is_branch = 1'b0;
      is_jal    = 1'b0;
      is_jalr   = 1'b0;
      case (opcode)
         OPC_LUI: begin
            fmt    = IMM_U;
            use_rd = 1'b1;
            alu_op = ALU_PASSB;
         end
         OPC_AUIPC: begin
            fmt    = IMM_U;
            use_rd = 1'b1;
         end
         OPC_JAL: begin
            fmt    = IMM_J;
            use_rd = 1'b1;
            is_jal = 1'b1;
         end
         OPC_JALR: begin
            fmt     = IMM_I;
            use_rd  = 1'b1;
            use_rs1 = 1'b1;
            is_jalr = 1'b1;
         end
         OPC_BRANCH: begin
            fmt       = IMM_B;
            use_rs1   = 1'b1;
            use_rs2   = 1'b1;
            is_branch = 1'b1;
            alu_op    = ALU_SUB;
            ill       = (f3 == 3'b010) || (f3 == 3'b011);
         end
         OPC_LOAD: begin
            fmt     = IMM_I;
            use_rd  = 1'b1;
            use_rs1 = 1'b1;
            is_load = 1'b1;
            ill     = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
         end
         OPC_STORE: begin
            fmt      = IMM_S;
            use_rs1  = 1'b1;
            use_rs2  = 1'b1;
            is_store = 1'b1;
            ill      = (f3 > 3'b010);
         end
         OPC_OP_IMM: begin
            fmt     = IMM_I;
            use_rd  = 1'b1;
            use_rs1 = 1'b1;
            case (f3)
               3'b000: alu_op = ALU_ADD;
               3'b001: begin
                  alu_op = ALU_SLL;
                  ill    = (f7 != F7_BASE);
               end
               3'b010: alu_op = ALU_SLT;
               3'b011: alu_op = ALU_SLTU;
               3'b100: alu_op = ALU_XOR;
               // Only the shift-immediates reuse the upper immediate bits as funct7.
               3'b101: begin
                  alu_op = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                  ill    = (f7 != F7_BASE) && (f7 != F7_ALT);
               end
               3'b110: alu_op = ALU_OR;
               default: alu_op = ALU_AND;
            endcase
         end
         OPC_OP: begin
            use_rd  = 1'b1;
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            case (f3)
               3'b000:  alu_op = f7[5] ? ALU_SUB : ALU_ADD;
               3'b001:  alu_op = ALU_SLL;
               3'b010:  alu_op = ALU_SLT;
               3'b011:  alu_op = ALU_SLTU;
               3'b100:  alu_op = ALU_XOR;
               3'b101:  alu_op = f7[5] ? ALU_SRA : ALU_SRL;
               3'b110:  alu_op = ALU_OR;
               default: alu_op = ALU_AND;
            endcase
            ill = !((f7 == F7_BASE) ||
                    ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))));
         end
         OPC_MISC_MEM, OPC_SYSTEM: begin
            // Fences and system instructions retire as no-ops in this core.
            fmt = IMM_NONE;
         end
         default: ill = 1'b1;
      endcase
      if (instr[1:0] != 2'b11) begin
         ill = 1'b1;
      end
   end

   always_comb begin
      dec        = '0;
      dec.funct3 = f3;
      if (ill) begin
         dec.illegal = 1'b1;
         dec.alu_op  = ALU_ADD;
      end else begin
         dec.rs1       = use_rs1 ? instr[19:15] : 5'd0;
         dec.rs2       = use_rs2 ? instr[24:20] : 5'd0;
         dec.rd        = use_rd  ? instr[11:7]  : 5'd0;
         dec.imm       = gen_imm(fmt, instr);
         dec.alu_op    = alu_op;
         dec.use_rs1   = use_rs1;
         dec.use_rs2   = use_rs2;
         dec.we_rd     = use_rd && (instr[11:7] != 5'd0);
         dec.is_load   = is_load;
         dec.is_store  = is_store;
         dec.is_branch = is_branch;
         dec.is_jal    = is_jal;
         dec.is_jalr   = is_jalr;
      end
   end

endmodule

// File: rtl/id_stage.sv
// RV32I instruction-decode stage: one registered pipeline slot between fetch
// and execute, with the decode logic held in rv32i_decoder.
module id_stage
   import k11_pkg::*;
#(
   parameter int                XLEN     = 32,
   parameter logic [XLEN-1:0]   RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [XLEN-1:0] pc_i,
   input  logic [31:0]     instr_i,
   input  logic            flush_i,
   output logic            valid_o,
   input  logic            ready_i,
   output logic [XLEN-1:0] pc_o,
   output logic [4:0]      rs1_o,
   output logic [4:0]      rs2_o,
   output logic [4:0]      rd_o,
   output logic [XLEN-1:0] imm_o,
   output logic [3:0]      alu_op_o,
   output logic            use_rs1_o,
   output logic            use_rs2_o,
   output logic            we_rd_o,
   output logic            is_load_o,
   output logic            is_store_o,
   output logic            is_branch_o,
   output logic            is_jal_o,
   output logic            is_jalr_o,
   output logic [2:0]      funct3_o,
   output logic            illegal_o
);

   dec_t            dec;
   dec_t            dec_q;
   logic [XLEN-1:0] pc_q;
   logic            valid_q;
   logic            cke;

   rv32i_decoder u_dec (
      .instr (instr_i),
      .dec   (dec)
   );

   // Handshake: a beat moves on a side when valid and ready are both high at
   // the rising edge; the slot advances whenever it is empty or being drained
   // (cke), so ready_o depends only on the slot state and ready_i, and
   // back-to-back beats flow with no bubble.
   assign cke     = ~valid_q | ready_i;
   assign ready_o = cke;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q       <= 1'b0;
         pc_q          <= RESET_PC;
         dec_q         <= '0;
         dec_q.alu_op  <= ALU_ADD;
      end else if (flush_i) begin
         valid_q <= 1'b0;
      end else if (cke) begin
         valid_q <= valid_i;
         if (valid_i) begin
            pc_q  <= pc_i;
            dec_q <= dec;
         end
      end
   end

   assign valid_o     = valid_q;
   assign pc_o        = valid_q ? pc_q : RESET_PC;
   assign rs1_o       = dec_q.rs1;
   assign rs2_o       = dec_q.rs2;
   assign rd_o        = dec_q.rd;
   assign imm_o       = dec_q.imm;
   assign alu_op_o    = dec_q.alu_op;
   assign use_rs1_o   = dec_q.use_rs1;
   assign use_rs2_o   = dec_q.use_rs2;
   assign we_rd_o     = dec_q.we_rd;
   assign is_load_o   = dec_q.is_load;
   assign is_store_o  = dec_q.is_store;
   assign is_branch_o = dec_q.is_branch;
   assign is_jal_o    = dec_q.is_jal;
   assign is_jalr_o   = dec_q.is_jalr;
   assign funct3_o    = dec_q.funct3;
   assign illegal_o   = dec_q.illegal;

endmodule
